// File: rtl/phase_scan_pkg.sv
// Shared types and constants for the phase_scan sweep engine.
// PHASE_SCAN_TRACK_EN adds the TRACK state used for post-sweep peak tracking.
package phase_scan_pkg;

    localparam int unsigned PHASE_W = 16;
    localparam int unsigned MAG_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_ACCUM  = 3'd2,
        S_EVAL   = 3'd3,
        S_DONE   = 3'd4
`ifdef PHASE_SCAN_TRACK_EN
        ,
        S_TRACK  = 3'd5
`endif
    } state_t;

endpackage

// File: rtl/scan_avg.sv
// Sample counter and accumulator: discards settle samples, then sums 2^AVG_LOG2 samples.
// Counter and accumulator clear whenever neither phase is active, or on clr.
module scan_avg
    import phase_scan_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned SETTLE   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             settling,
    input  logic             accumulating,
    input  logic             rdy,
    input  logic [MAG_W-1:0] value,
    output logic             settle_done_c,
    output logic             accum_done_c,
    output logic [MAG_W-1:0] avg_c
);

    localparam int unsigned ACC_W = MAG_W + AVG_LOG2;
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE == 0) ? 0 : SETTLE - 1);
    localparam logic [CNT_W-1:0] ACCUM_LAST  = CNT_W'((1 << AVG_LOG2) - 1);

    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;

    assign settle_done_c = settling && rdy && (cnt == SETTLE_LAST);
    assign accum_done_c  = accumulating && rdy && (cnt == ACCUM_LAST);
    assign avg_c         = MAG_W'(acc >> AVG_LOG2);

    always_ff @(posedge clk) begin
        if (rst || clr || !(settling || accumulating)) begin
            cnt <= '0;
            acc <= '0;
        end else if (settling) begin
            if (rdy) cnt <= settle_done_c ? '0 : cnt + CNT_W'(1);
        end else if (rdy) begin
            cnt <= accum_done_c ? '0 : cnt + CNT_W'(1);
            acc <= acc + ACC_W'(value);
        end
    end

endmodule

// File: rtl/phase_scan.sv
// Phase sweep: steps the demodulator phase, averages magnitude per step, reports the peak.
// Define PHASE_SCAN_TRACK_EN to keep tracking the peak (+/- one step) after a sweep.
module phase_scan
    import phase_scan_pkg::*;
#(
    parameter int unsigned STEP_LOG2 = 12,
    parameter int unsigned AVG_LOG2  = 2,
    parameter int unsigned SETTLE    = 1
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        start,
    input  logic [7:0]  value,
    input  logic        rdy,
    output logic [15:0] phase,
    output logic        busy,
    output logic        done,
    output logic [15:0] best_phase,
    output logic [7:0]  best_mag
);

    localparam logic [PHASE_W-1:0] STEP       = PHASE_W'(1 << STEP_LOG2);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'((1 << PHASE_W) - (1 << STEP_LOG2));
    localparam state_t             FIRST      = (SETTLE == 0) ? S_ACCUM : S_SETTLE;

    state_t             state;
    logic               settle_done_c;
    logic               accum_done_c;
    logic [MAG_W-1:0]   avg_c;
    logic               new_best_c;
    logic               restart_c;

`ifdef PHASE_SCAN_TRACK_EN
    logic               trk;
    logic [1:0]         tidx;
    logic [MAG_W-1:0]   centre_mag;
    logic [MAG_W-1:0]   plus_mag;
    assign restart_c = start && trk;
`else
    assign restart_c = 1'b0;
`endif

    assign new_best_c = avg_c > best_mag;

    scan_avg #(.AVG_LOG2(AVG_LOG2), .SETTLE(SETTLE)) u_avg (
        .clk           (clk),
        .rst           (rst_in),
        .clr           (restart_c),
        .settling      (state == S_SETTLE),
        .accumulating  (state == S_ACCUM),
        .rdy           (rdy),
        .value         (value),
        .settle_done_c (settle_done_c),
        .accum_done_c  (accum_done_c),
        .avg_c         (avg_c)
    );

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state      <= S_IDLE;
            phase      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            best_phase <= '0;
            best_mag   <= '0;
`ifdef PHASE_SCAN_TRACK_EN
            trk        <= 1'b0;
            tidx       <= '0;
            centre_mag <= '0;
            plus_mag   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    phase      <= '0;
                    best_phase <= '0;
                    best_mag   <= '0;
                    busy       <= 1'b1;
                    state      <= FIRST;
                end
                S_SETTLE: if (settle_done_c) state <= S_ACCUM;
                S_ACCUM:  if (accum_done_c) state <= S_EVAL;
                S_EVAL: begin
`ifdef PHASE_SCAN_TRACK_EN
                    if (trk) begin
                        // Triple order: centre, centre+step, centre-step; decide on the third.
                        if (tidx == 2'd0) begin
                            centre_mag <= avg_c;
                            phase      <= best_phase + STEP;
                            tidx       <= 2'd1;
                            state      <= FIRST;
                        end else if (tidx == 2'd1) begin
                            plus_mag   <= avg_c;
                            phase      <= best_phase - STEP;
                            tidx       <= 2'd2;
                            state      <= FIRST;
                        end else begin
                            if (plus_mag > centre_mag && plus_mag >= avg_c) begin
                                best_phase <= best_phase + STEP;
                                best_mag   <= plus_mag;
                                phase      <= best_phase + STEP;
                            end else if (avg_c > centre_mag) begin
                                best_phase <= best_phase - STEP;
                                best_mag   <= avg_c;
                                phase      <= best_phase - STEP;
                            end else begin
                                best_mag   <= centre_mag;
                                phase      <= best_phase;
                            end
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end
                    end else
`endif
                    begin
                        if (new_best_c) begin
                            best_mag   <= avg_c;
                            best_phase <= phase;
                        end
                        if (phase == LAST_PHASE) begin
                            phase <= new_best_c ? phase : best_phase;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            phase <= phase + STEP;
                            state <= FIRST;
                        end
                    end
                end
`ifdef PHASE_SCAN_TRACK_EN
                S_DONE: begin
                    trk   <= 1'b1;
                    busy  <= 1'b1;
                    state <= S_TRACK;
                end
                S_TRACK: begin
                    phase <= best_phase;
                    tidx  <= 2'd0;
                    state <= FIRST;
                end
`else
                S_DONE: state <= S_IDLE;
`endif
                default: state <= S_IDLE;
            endcase
`ifdef PHASE_SCAN_TRACK_EN
            // A start while tracking abandons the track and begins a fresh sweep.
            if (restart_c && state != S_DONE) begin
                phase      <= '0;
                best_phase <= '0;
                best_mag   <= '0;
                busy       <= 1'b1;
                done       <= 1'b0;
                trk        <= 1'b0;
                state      <= FIRST;
            end
`endif
        end
    end

endmodule

// File: doc/phase_scan.md
PHASE_SCAN -- requirements
Module: phase_scan

Interface
REQ-001 SHALL have parameter STEP_LOG2, default 12, phase step = 2^STEP_LOG2 (16 steps per sweep); legal range 8..14.
REQ-002 SHALL have parameter AVG_LOG2, default 2, samples averaged per step = 2^AVG_LOG2; legal range 0..4.
REQ-003 SHALL have parameter SETTLE, default 1, number of rdy pulses discarded after each phase change; legal range 0..7.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_in  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port start  input  1  single-cycle sweep request.
REQ-007 SHALL have port value  input  8  demodulator magnitude sample, unsigned.
REQ-008 SHALL have port rdy  input  1  single-cycle strobe qualifying value.
REQ-009 SHALL have port phase  output  16  phase offset driven to the demodulator.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE and DONE.
REQ-011 SHALL have port done  output  1  single-cycle result-valid pulse.
REQ-012 SHALL have port best_phase  output  16  phase of the largest averaged magnitude.
REQ-013 SHALL have port best_mag  output  8  largest averaged magnitude.

Function
REQ-014 SHALL implement the states IDLE, SETTLE, ACCUM, EVAL, DONE.
REQ-015 IDLE: start -> phase=0, settle counter cleared, best_mag=0, best_phase=0 -> SETTLE; rdy ignored.
REQ-016 SETTLE: count rdy pulses; after SETTLE pulses -> ACCUM (SETTLE=0 -> directly to ACCUM).
REQ-017 ACCUM: add value to an (8+AVG_LOG2)-bit accumulator on each rdy; after 2^AVG_LOG2 samples -> EVAL.
REQ-018 EVAL (one cycle): avg = acc >> AVG_LOG2; if avg > best_mag strictly, update best_mag and best_phase=phase; ties keep the earlier phase.
REQ-019 EVAL, not last step: phase += 2^STEP_LOG2, clear acc -> SETTLE.
REQ-020 EVAL, last step (phase == 0x10000 - 2^STEP_LOG2): -> DONE; phase SHALL NOT wrap to 0.
REQ-021 DONE: done=1 for exactly one cycle, phase driven to best_phase in that same cycle, then -> IDLE; phase holds best_phase in IDLE.
REQ-022 start SHALL be ignored in every state except IDLE.
REQ-023 rdy in EVAL or DONE SHALL be dropped, not counted.
REQ-024 Sweep length SHALL be exactly 2^(16-STEP_LOG2) EVAL cycles.

Reset
REQ-025 rst_in SHALL force IDLE and phase=0, busy=0, done=0, best_phase=0, best_mag=0, all counters and acc cleared, from any state including mid-sweep; no done pulse results.

Configuration
REQ-026 With PHASE_SCAN_TRACK_EN defined, DONE SHALL go to state TRACK instead of IDLE: repeating measurements (SETTLE+ACCUM each) at best_phase, best_phase+step, best_phase-step (mod 2^16); best_phase moves to the neighbour whose avg strictly exceeds the centre avg, best_mag takes the winning avg, done pulses once per triple; start or rst_in leaves TRACK (start restarts a sweep); busy=1 in TRACK.
REQ-027 Without PHASE_SCAN_TRACK_EN, no TRACK state or tracking logic SHALL be synthesised.

Structure
REQ-028 Shared package SHALL hold the state encoding and the phase width constant (16).
REQ-029 One sub-module, scan_avg (sample counter + accumulator + shift), SHALL serve SETTLE/ACCUM.

Verification
REQ-030 Defaults; model returns 100 at phase 0x5000, 20 elsewhere; start -> 16 steps, done once, best_phase=0x5000, best_mag=100, phase=0x5000.
REQ-031 Flat 50 everywhere -> best_phase=0x0000 (tie rule), best_mag=50.
REQ-032 AVG_LOG2=2, samples 10,20,30,41 at 0x3000, 0 elsewhere -> best_mag=25 (truncation), best_phase=0x3000.
REQ-033 rst_in asserted during step 7 -> next cycle phase=0, busy=0, no done; new start completes a normal sweep.
REQ-034 start pulsed while busy and rdy pulsed in EVAL -> ignored; sample count per step stays 1 settle + 4 accumulated.
REQ-035 PHASE_SCAN_TRACK_EN; peak moved from 0x5000 to 0x6000 after sweep -> within two triples best_phase=0x6000.
